// File: rtl/dvs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dvs_pkg
// Description : Shared DVS event-stream types and widths. Used by the frame
//               event serializer and by the event-window accumulator.
// Contents    : COORD_W, TS_W, dvs_event_t, fes_state_t
// Revision    : 1.0 - initial release
// ============================================================================
package dvs_pkg;

  localparam int COORD_W = 14;
  localparam int TS_W    = 34;

  typedef struct packed {
    logic [TS_W-1:0]    ts;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               pol;
  } dvs_event_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } fes_state_t;

endpackage : dvs_pkg
`default_nettype wire

// File: rtl/lsb_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : lsb_priority_encoder
// Description : Combinational lowest-set-bit finder.
// Ports       : i_word  [WORD_W-1:0]         word to examine
//               o_any                         at least one bit of i_word set
//               o_index [$clog2(WORD_W)-1:0]  position of the lowest set bit
//                                             (0 when o_any is low)
// Revision    : 1.0 - initial release
// ============================================================================
module lsb_priority_encoder #(
  parameter int WORD_W = 64
) (
  input  logic [WORD_W-1:0]         i_word,
  output logic                      o_any,
  output logic [$clog2(WORD_W)-1:0] o_index
);

  localparam int c_IDX_W = $clog2(WORD_W);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    o_index = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (i_word[i]) begin
        o_index = c_IDX_W'(i);
      end
    end
  end

  assign o_any = |i_word;

endmodule : lsb_priority_encoder
`default_nettype wire

// File: rtl/frame_event_serializer.sv
`default_nettype none
// ============================================================================
// Module      : frame_event_serializer
// Description : Takes a binary X_SIZE*Y_SIZE frame plus a timestamp and emits
//               one DVS event (ts, x, y, polarity) per set pixel, in ascending
//               pixel order, over a valid/ready stream. The frame is scanned
//               WORD_W bits per cycle; all-zero words cost one cycle each.
// Ports       : clk, reset (async, active low)
//               in_frame/in_timestamp/in_valid/in_ready  frame input stream
//               timestamp/x_coord/y_coord/polarity/is_valid/out_ready
//                                                          event output stream
//               frame_done  one-cycle pulse after the last word is scanned
//               busy        a frame is held
// Revision    : 1.0 - initial release
// ============================================================================
module frame_event_serializer
  import dvs_pkg::*;
#(
  parameter int   X_SIZE     = 64,
  parameter int   Y_SIZE     = 64,
  parameter int   INPUT_SIZE = X_SIZE * Y_SIZE,
  parameter int   WORD_W     = 64,
  parameter int   SCALE      = 2,
  parameter logic POLARITY   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INPUT_SIZE-1:0] in_frame,
  input  logic [TS_W-1:0]       in_timestamp,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [TS_W-1:0]       timestamp,
  output logic [COORD_W-1:0]    x_coord,
  output logic [COORD_W-1:0]    y_coord,
  output logic                  polarity,
  output logic                  is_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int c_NUM_WORDS = INPUT_SIZE / WORD_W;
  localparam int c_IDX_W     = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;
  localparam int c_BIT_W     = $clog2(WORD_W);
  localparam logic [c_IDX_W-1:0] c_LAST_WORD = c_IDX_W'(c_NUM_WORDS - 1);

  fes_state_t                r_state;
  fes_state_t                w_state_nxt;
  logic [INPUT_SIZE-1:0]     r_shadow;
  logic [c_IDX_W-1:0]        r_word_idx;
  logic [TS_W-1:0]           r_ts;

  logic [WORD_W-1:0]         w_cur;
  logic [WORD_W-1:0]         w_cur_clr;
  logic                      w_any;
  logic [c_BIT_W-1:0]        w_bit_idx;
  logic [31:0]               w_pix;
  logic                      w_accept;
  logic                      w_pop;
  logic                      w_advance;
  dvs_event_t                w_evt;

  assign w_cur     = r_shadow[r_word_idx*WORD_W +: WORD_W];
  // x & (x-1) drops exactly the lowest set bit, i.e. the one being emitted.
  assign w_cur_clr = w_cur & (w_cur - WORD_W'(1));

  lsb_priority_encoder #(
    .WORD_W (WORD_W)
  ) u_lsb_enc (
    .i_word  (w_cur),
    .o_any   (w_any),
    .o_index (w_bit_idx)
  );

  // WORD_W is a power of two, so word index and bit index simply concatenate.
  assign w_pix = 32'({r_word_idx, w_bit_idx});

  // in_ready is forced low while reset is asserted even though state is IDLE.
  assign in_ready   = (r_state == IDLE) && reset;
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == DONE);
  assign is_valid   = (r_state == SCAN) && w_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_pop       = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (w_any) begin
          if (out_ready) begin
            w_pop     = 1'b1;
            w_advance = (w_cur_clr == '0);
          end
        end else begin
          w_advance = 1'b1;
        end
        if (w_advance && (r_word_idx == c_LAST_WORD)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow   <= '0;
      r_ts       <= '0;
      r_word_idx <= '0;
    end else if (w_accept) begin
      r_shadow   <= in_frame;
      r_ts       <= in_timestamp;
      r_word_idx <= '0;
    end else begin
      if (w_pop) begin
        r_shadow[r_word_idx*WORD_W +: WORD_W] <= w_cur_clr;
      end
      if (w_advance) begin
        r_word_idx <= (r_word_idx == c_LAST_WORD) ? '0 : r_word_idx + 1'b1;
      end
    end
  end

  // Event fields come only from registered state; zero when no event.
  // The row is reduced modulo Y_SIZE so an oversized INPUT_SIZE wraps rows.
  always_comb begin
    w_evt = '0;
    if (is_valid) begin
      w_evt.ts  = r_ts;
      w_evt.x   = COORD_W'((w_pix % X_SIZE) * SCALE);
      w_evt.y   = COORD_W'(((w_pix / X_SIZE) % Y_SIZE) * SCALE);
      w_evt.pol = POLARITY;
    end
  end

  assign timestamp = w_evt.ts;
  assign x_coord   = w_evt.x;
  assign y_coord   = w_evt.y;
  assign polarity  = w_evt.pol;

endmodule : frame_event_serializer
`default_nettype wire

// File: tb/tb_frame_event_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_event_serializer
// Description : Self-checking bench for frame_event_serializer. A queue of
//               expected events is built from each accepted frame (every set
//               pixel in ascending index order); a negedge compare process
//               checks every emitted event and every frame_done against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_event_serializer;

  localparam int XS   = 64;
  localparam int NPIX = 4096;

  logic            clk = 1'b0;
  logic            reset;
  logic [NPIX-1:0] in_frame;
  logic [33:0]     in_timestamp;
  logic            in_valid;
  logic            in_ready;
  logic [33:0]     timestamp;
  logic [13:0]     x_coord;
  logic [13:0]     y_coord;
  logic            polarity;
  logic            is_valid;
  logic            out_ready;
  logic            frame_done;
  logic            busy;

  frame_event_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .in_frame     (in_frame),
    .in_timestamp (in_timestamp),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .timestamp    (timestamp),
    .x_coord      (x_coord),
    .y_coord      (y_coord),
    .polarity     (polarity),
    .is_valid     (is_valid),
    .out_ready    (out_ready),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] ts;
    logic [13:0] x;
    logic [13:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   cyc         = 0;
  int   frames_done = 0;
  int   frames_exp  = 0;
  int   rdy_mode    = 0;
  int   pat_i       = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected events: every set pixel, ascending index, scaled coordinates.
  function automatic void model_push(input logic [NPIX-1:0] f, input logic [33:0] ts);
    exp_t e;
    for (int p = 0; p < NPIX; p++) begin
      if (f[p]) begin
        e.ts = ts;
        e.x  = 14'((p % XS) * 2);
        e.y  = 14'((p / XS) * 2);
        exp_q.push_back(e);
      end
    end
  endfunction

  // Cycles from acceptance edge (inclusive) to frame_done with out_ready high.
  function automatic int model_cycles(input logic [NPIX-1:0] f);
    int n;
    n = 1;
    for (int w = 0; w < NPIX / 64; w++) begin
      if (f[w*64 +: 64] == 64'd0) n++;
    end
    for (int p = 0; p < NPIX; p++) begin
      if (f[p]) n++;
    end
    return n;
  endfunction

  // out_ready driver: 0 = always high, 1 = random, 2 = pattern 1,0,0,1.
  always @(posedge clk) begin
    logic [3:0] pat;
    #1;
    pat = 4'b1001;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        out_ready = pat[3 - pat_i];
        pat_i     = (pat_i + 1) % 4;
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Compare process: every event and every frame_done against the model.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (is_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event_x", 64'(x_coord), 64'h3fff_ffff);
        end else begin
          chk("event_ts", 64'(timestamp), 64'(exp_q[0].ts));
          chk("event_x", 64'(x_coord), 64'(exp_q[0].x));
          chk("event_y", 64'(y_coord), 64'(exp_q[0].y));
          chk("event_pol", 64'(polarity), 64'd1);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (frame_done) begin
        chk("pending_at_frame_done", 64'(exp_q.size()), 64'd0);
        frames_done++;
      end
    end
  end

  task automatic send_frame(input logic [NPIX-1:0] f, input logic [33:0] ts,
                            output int acc_cyc);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    in_frame     = f;
    in_timestamp = ts;
    in_valid     = 1'b1;
    acc_cyc      = -1;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        model_push(f, ts);
        frames_exp++;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        got     = 1;
      end
    end
    in_valid = 1'b0;
    if (!got) chk("frame_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int bound, output int done_cyc);
    bit got;
    got      = 0;
    done_cyc = -1;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      if (frame_done) begin
        done_cyc = cyc;
        got      = 1;
      end
    end
    if (!got) chk("frame_done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NPIX-1:0] f;
    logic [NPIX-1:0] g;
    int a, d, nf;

    reset        = 1'b0;
    in_frame     = '0;
    in_timestamp = '0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_is_valid", 64'(is_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_coords", 64'({x_coord, y_coord}), 64'd0);
    chk("rst_ts", 64'(timestamp), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Bits 0, 65, 4095 at ts=1000
    f = '0; f[0] = 1'b1; f[65] = 1'b1; f[4095] = 1'b1;
    send_frame(f, 34'd1000, a);
    chk("model_size", 64'(exp_q.size()), 64'd3);
    chk("model_e1_xy", 64'({exp_q[1].x, exp_q[1].y}), 64'({14'd2, 14'd2}));
    chk("model_e2_xy", 64'({exp_q[2].x, exp_q[2].y}), 64'({14'd126, 14'd126}));
    chk("model_cycles_3pix", 64'(model_cycles(f)), 64'd65);
    @(negedge clk);
    chk("first_event_valid", 64'(is_valid), 64'd1);
    chk("first_event_xy", 64'({x_coord, y_coord}), 64'd0);
    chk("first_event_ts", 64'(timestamp), 64'd1000);
    wait_done(200, d);
    chk("3pix_done_cycles", 64'(d - a + 1), 64'd65);
    @(negedge clk);
    chk("busy_falls", 64'(busy), 64'd0);

    // Empty frame
    f = '0;
    send_frame(f, 34'd7, a);
    wait_done(200, d);
    chk("empty_done_cycles", 64'(d - a + 1), 64'd65);

    // 1-0-0-1 out_ready on a four-pixel word
    f = '0; f[5*64+3] = 1'b1; f[5*64+10] = 1'b1; f[5*64+20] = 1'b1; f[5*64+63] = 1'b1;
    pat_i    = 0;
    rdy_mode = 2;
    send_frame(f, 34'h2_0000_0055, a);
    wait_done(400, d);
    rdy_mode = 0;

    // Second frame offered while busy is ignored until IDLE
    f = '0; f[100] = 1'b1; f[2000] = 1'b1;
    g = '0; g[1] = 1'b1; g[4000] = 1'b1;
    send_frame(f, 34'd300, a);
    for (int k = 0; k < 5; k++) begin
      in_frame     = g;
      in_timestamp = 34'd301;
      in_valid     = 1'b1;
      @(negedge clk);
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    send_frame(g, 34'd301, a);
    wait_done(200, d);

    // Reset mid-scan of a ten-pixel frame
    f = '0;
    for (int i = 0; i < 10; i++) f[i*400] = 1'b1;
    send_frame(f, 34'd500, a);
    repeat (20) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    frames_exp--;
    nf = frames_done;
    @(negedge clk);
    chk("abort_is_valid", 64'(is_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (70) @(negedge clk);
    chk("abort_no_frame_done", 64'(frames_done), 64'(nf));
    g = '0; g[7] = 1'b1; g[3333] = 1'b1;
    send_frame(g, 34'd600, a);
    wait_done(200, d);

    // Full frame, one event per cycle
    f = '1;
    send_frame(f, 34'd900, a);
    wait_done(5000, d);
    chk("full_done_cycles", 64'(d - a + 1), 64'd4097);

    // Random frames under random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 8; n++) begin
      f = '0;
      if (n % 2 == 0) begin
        for (int k = 0; k < int'($urandom_range(0, 40)); k++) f[$urandom_range(0, NPIX-1)] = 1'b1;
      end else begin
        for (int k = 0; k < 3; k++) f[$urandom_range(0, 63)*64 +: 64] = {$urandom, $urandom};
      end
      send_frame(f, 34'({$urandom_range(0, 3), $urandom}), a);
      wait_done(3000, d);
    end
    rdy_mode = 0;

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_frame_count", 64'(frames_done), 64'(frames_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_frame_event_serializer
`default_nettype wire
